// File: rtl/divisor_pkg.sv
// Shared constants, mode encoding and helpers for the multi-channel clock divider.
package divisor_pkg;

    // Board-level defaults: 50 MHz / (2 * 8_333_334) gives the legacy ~3 Hz square wave.
    localparam int unsigned CNT_W_DEF       = 25;
    localparam int unsigned DEFAULT_DIV_50M = 8_333_333;

    // Output mode encoding for each channel.
    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // What a channel does on the coming clock edge, highest priority first:
    // restart > load > wrap/count > hold.
    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_COUNT   = 3'd1,
        ACT_WRAP    = 3'd2,
        ACT_LOAD    = 3'd3,
        ACT_RESTART = 3'd4
    } chan_act_e;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divisor_channel.sv
// One divider channel: programmable limit, counter, square-wave bit, tick bit
// and the mode mux that selects which of the two drives clk_out_o.
module divisor_channel
    import divisor_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_50M
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             restart_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output chan_act_e        act_o
);

    localparam logic [CNT_W-1:0] LIM_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    chan_act_e        act;

    // Pick the single action for this edge according to the priority order.
    always_comb begin
        act = ACT_HOLD;
        if (restart_i) begin
            act = ACT_RESTART;
        end else if (load_i) begin
            act = ACT_LOAD;
        end else if (en_i) begin
            // >= rather than == so a counter can never sit above its limit.
            act = (cnt_q >= lim_q) ? ACT_WRAP : ACT_COUNT;
        end
    end

    // Next-state values for the selected action; tick is a one-cycle pulse by default.
    always_comb begin
        lim_d  = lim_q;
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        case (act)
            ACT_RESTART: begin
                // Restart clears phase but a simultaneous load still updates the limit.
                cnt_d = '0;
                sq_d  = 1'b0;
                if (load_i) begin
                    lim_d = load_val_i;
                end
            end
            ACT_LOAD: begin
                // New limit, phase-aligned restart; any wrap this cycle is dropped.
                lim_d = load_val_i;
                cnt_d = '0;
                sq_d  = 1'b0;
            end
            ACT_WRAP: begin
                cnt_d  = '0;
                sq_d   = ~sq_q;
                tick_d = 1'b1;
            end
            ACT_COUNT: begin
                // cnt_q < lim_q here, so the increment cannot overflow.
                cnt_d = cnt_q + CNT_ONE;
            end
            default: begin
                // Hold: counter and square bit keep their values.
                cnt_d = cnt_q;
            end
        endcase
    end

    // Channel state registers with asynchronous active-high reset.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            lim_q  <= LIM_RST;
            cnt_q  <= '0;
            sq_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            lim_q  <= lim_d;
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
        end
    end

    // Both mux inputs are flop outputs, so the selected output is glitch-free per mode.
    assign clk_out_o = (mode_i == MODE_PULSE) ? tick_q : sq_q;
    assign tick_o    = tick_q;
    assign act_o     = act;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel run-time-programmable clock divider on the 50 MHz board clock.
// Load interface: load is a single-cycle strobe with no handshake; on the edge
// where load = 1, load_val is written to the limit of channel load_ch and that
// channel restarts from count 0. A load_ch beyond the last channel is dropped.
module clk_divider_multi
    import divisor_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_50M,
    localparam int unsigned LCH_W      = sel_width(NUM_CH)
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              restart,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              load,
    input  logic [LCH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // Elaboration-time parameter sanity.
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("clk_divider_multi: NUM_CH must be 1..8");
    end
    if (CNT_W < 32 && DEFAULT_DIV >= (32'd1 << CNT_W)) begin : g_bad_default
        $error("clk_divider_multi: DEFAULT_DIV does not fit in CNT_W");
    end

    logic              load_in_range;
    logic [NUM_CH-1:0] load_hit;
    chan_act_e         ch_act [NUM_CH];

    // Out-of-range selects cannot reach any channel.
    assign load_in_range = (32'(load_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Per-channel load strobe decoded from the shared select.
        assign load_hit[i] = load && load_in_range && (load_ch == LCH_W'(i));

        divisor_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_50MHz  (clk_50MHz),
            .reset      (reset),
            .restart_i  (restart),
            .en_i       (en[i]),
            .mode_i     (mode[i]),
            .load_i     (load_hit[i]),
            .load_val_i (load_val),
            .clk_out_o  (clk_out[i]),
            .tick_o     (tick[i]),
            .act_o      (ch_act[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with DEFAULT_DIV = 4, CNT_W = 8.
module tb_clk_divider_multi;

    localparam int unsigned CW = 8;

    // clock / reset
    logic clk_50MHz = 1'b0;
    logic reset     = 1'b1;
    always #5 clk_50MHz = ~clk_50MHz;

    // main DUT: two channels
    logic          restart  = 1'b0;
    logic [1:0]    en       = '0;
    logic [1:0]    mode     = '0;
    logic          load     = 1'b0;
    logic [0:0]    load_ch  = '0;
    logic [CW-1:0] load_val = '0;
    logic [1:0]    clk_out;
    logic [1:0]    tick;

    // second DUT: three channels, so an out-of-range select is expressible
    logic          restart3  = 1'b0;
    logic [2:0]    en3       = '0;
    logic [2:0]    mode3     = '0;
    logic          load3     = 1'b0;
    logic [1:0]    load_ch3  = '0;
    logic [CW-1:0] load_val3 = '0;
    logic [2:0]    clk_out3;
    logic [2:0]    tick3;

    int n_cmp = 0;
    int n_err = 0;

    clk_divider_multi #(.CNT_W(CW), .NUM_CH(2), .DEFAULT_DIV(4)) u_dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .restart   (restart),
        .en        (en),
        .mode      (mode),
        .load      (load),
        .load_ch   (load_ch),
        .load_val  (load_val),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    clk_divider_multi #(.CNT_W(CW), .NUM_CH(3), .DEFAULT_DIV(4)) u_dut3 (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .restart   (restart3),
        .en        (en3),
        .mode      (mode3),
        .load      (load3),
        .load_ch   (load_ch3),
        .load_val  (load_val3),
        .clk_out   (clk_out3),
        .tick      (tick3)
    );

    // one active edge, then return at the falling edge where outputs are stable
    task automatic cyc();
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        n_cmp++;
        if (clk_out !== 2'b00) begin
            n_err++;
            $display("FAIL reset_clk_out: got %b want 00", clk_out);
        end
        n_cmp++;
        if (tick !== 2'b00) begin
            n_err++;
            $display("FAIL reset_tick: got %b want 00", tick);
        end
        n_cmp++;
        if ({clk_out3, tick3} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_dut3: got %b want 000000", {clk_out3, tick3});
        end
        reset = 1'b0;
    endtask

    // toggle mode, default limit 4: tick on edges 5,10,..; square flips there
    task automatic test_count();
        logic t, s;
        en   = 2'b11;
        mode = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            t = (k % 5 == 0);
            s = ((k / 5) % 2 == 1);
            n_cmp++;
            if (tick !== {t, t}) begin
                n_err++;
                $display("FAIL count_tick k=%0d: got %b want %b", k, tick, {t, t});
            end
            n_cmp++;
            if (clk_out !== {s, s}) begin
                n_err++;
                $display("FAIL count_clk_out k=%0d: got %b want %b", k, clk_out, {s, s});
            end
        end
    endtask

    // channel 1 to pulse mode mid-run; channel 0 keeps its square wave
    task automatic test_mode_switch();
        logic t, s;
        mode = 2'b10;
        for (int k = 21; k <= 34; k++) begin
            cyc();
            t = (k % 5 == 0);
            s = ((k / 5) % 2 == 1);
            n_cmp++;
            if (tick !== {t, t}) begin
                n_err++;
                $display("FAIL mode_tick k=%0d: got %b want %b", k, tick, {t, t});
            end
            n_cmp++;
            if (clk_out !== {t, s}) begin
                n_err++;
                $display("FAIL mode_clk_out k=%0d: got %b want %b", k, clk_out, {t, s});
            end
        end
    endtask

    // load ch1 with 2 on the edge where ch1 would wrap (edge 35)
    task automatic test_load_on_wrap();
        logic t0, s0, t1, s1;
        int m;
        load     = 1'b1;
        load_ch  = 1'b1;
        load_val = 8'd2;
        cyc();
        load = 1'b0;
        n_cmp++;
        if (tick !== 2'b01) begin
            n_err++;
            $display("FAIL load_wrap_tick: got %b want 01", tick);
        end
        n_cmp++;
        if (clk_out !== 2'b01) begin
            n_err++;
            $display("FAIL load_wrap_pulse_out: got %b want 01", clk_out);
        end
        mode = 2'b00;
        #1;
        n_cmp++;
        if (clk_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL load_wrap_sq1: got %b want 0", clk_out[1]);
        end
        for (int k = 36; k <= 47; k++) begin
            cyc();
            m  = k - 35;
            t0 = (k % 5 == 0);
            s0 = ((k / 5) % 2 == 1);
            t1 = (m % 3 == 0);
            s1 = ((m / 3) % 2 == 1);
            n_cmp++;
            if (tick !== {t1, t0}) begin
                n_err++;
                $display("FAIL newlim_tick k=%0d: got %b want %b", k, tick, {t1, t0});
            end
            n_cmp++;
            if (clk_out !== {s1, s0}) begin
                n_err++;
                $display("FAIL newlim_clk_out k=%0d: got %b want %b", k, clk_out, {s1, s0});
            end
        end
    endtask

    // en[0] low for 7 cycles with cnt0 = 2 and sq0 = 1, then resume
    task automatic test_enable_hold();
        logic t0, s0, t1, s1;
        int m;
        en = 2'b10;
        for (int k = 48; k <= 57; k++) begin
            if (k == 55) en = 2'b11;
            cyc();
            m  = k - 35;
            t1 = (m % 3 == 0);
            s1 = ((m / 3) % 2 == 1);
            t0 = (k == 57);
            s0 = (k != 57);
            n_cmp++;
            if (tick !== {t1, t0}) begin
                n_err++;
                $display("FAIL hold_tick k=%0d: got %b want %b", k, tick, {t1, t0});
            end
            n_cmp++;
            if (clk_out !== {s1, s0}) begin
                n_err++;
                $display("FAIL hold_clk_out k=%0d: got %b want %b", k, clk_out, {s1, s0});
            end
        end
    endtask

    // async reset while tick0 and clk_out1 are high; ch1 limit must return to 4
    task automatic test_async_reset();
        logic t, s;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tick !== 2'b00) begin
            n_err++;
            $display("FAIL async_tick: got %b want 00", tick);
        end
        n_cmp++;
        if (clk_out !== 2'b00) begin
            n_err++;
            $display("FAIL async_clk_out: got %b want 00", clk_out);
        end
        @(negedge clk_50MHz);
        reset = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            t = (j % 5 == 0);
            s = ((j / 5) % 2 == 1);
            n_cmp++;
            if (tick !== {t, t}) begin
                n_err++;
                $display("FAIL post_reset_tick j=%0d: got %b want %b", j, tick, {t, t});
            end
            n_cmp++;
            if (clk_out !== {s, s}) begin
                n_err++;
                $display("FAIL post_reset_clk_out j=%0d: got %b want %b", j, clk_out, {s, s});
            end
        end
    endtask

    // restart and load (ch0 <= 1) together while both squares are high
    task automatic test_restart_load();
        logic t0, s0, t1, s1;
        restart  = 1'b1;
        load     = 1'b1;
        load_ch  = 1'b0;
        load_val = 8'd1;
        cyc();
        restart = 1'b0;
        load    = 1'b0;
        n_cmp++;
        if ({clk_out, tick} !== 4'b0000) begin
            n_err++;
            $display("FAIL restart_clear: got %b want 0000", {clk_out, tick});
        end
        for (int j = 1; j <= 10; j++) begin
            cyc();
            t0 = (j % 2 == 0);
            s0 = ((j / 2) % 2 == 1);
            t1 = (j % 5 == 0);
            s1 = ((j / 5) % 2 == 1);
            n_cmp++;
            if (tick !== {t1, t0}) begin
                n_err++;
                $display("FAIL restart_tick j=%0d: got %b want %b", j, tick, {t1, t0});
            end
            n_cmp++;
            if (clk_out !== {s1, s0}) begin
                n_err++;
                $display("FAIL restart_clk_out j=%0d: got %b want %b", j, clk_out, {s1, s0});
            end
        end
    endtask

    // limit 0: tick stuck high, square toggles every cycle
    task automatic test_load_zero();
        load     = 1'b1;
        load_ch  = 1'b0;
        load_val = 8'd0;
        cyc();
        load = 1'b0;
        n_cmp++;
        if ({clk_out[0], tick[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL zero_load: got %b want 00", {clk_out[0], tick[0]});
        end
        for (int j = 1; j <= 6; j++) begin
            cyc();
            n_cmp++;
            if ({clk_out[0], tick[0]} !== {1'(j % 2), 1'b1}) begin
                n_err++;
                $display("FAIL zero_run j=%0d: got %b want %b", j, {clk_out[0], tick[0]},
                         {1'(j % 2), 1'b1});
            end
        end
    endtask

    // load_ch = 3 on a three-channel divider: every limit stays at 4
    task automatic test_out_of_range();
        logic t, s;
        en3       = 3'b111;
        mode3     = 3'b000;
        load3     = 1'b1;
        load_ch3  = 2'd3;
        load_val3 = 8'd1;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            load3 = 1'b0;
            t = (j % 5 == 0);
            s = ((j / 5) % 2 == 1);
            n_cmp++;
            if (tick3 !== {t, t, t}) begin
                n_err++;
                $display("FAIL oor_tick j=%0d: got %b want %b", j, tick3, {t, t, t});
            end
            n_cmp++;
            if (clk_out3 !== {s, s, s}) begin
                n_err++;
                $display("FAIL oor_clk_out j=%0d: got %b want %b", j, clk_out3, {s, s, s});
            end
        end
    endtask

    initial begin
        @(negedge clk_50MHz);
        test_reset();
        test_count();
        test_mode_switch();
        test_load_on_wrap();
        test_enable_hold();
        test_async_reset();
        test_restart_load();
        test_load_zero();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
